// File: rtl/chip8_host_ctrl.sv
// CHIP-8 host control block: host register file, return stack, framebuffer pulse and memory window.
// Build option: define CHIP8_STACK_GUARD_EN to block push-when-full / pop-when-empty and keep sticky flags.
module chip8_host_ctrl #(
    parameter int STACK_DEPTH = 16,
    parameter int PC_W        = 12,
    parameter int FB_X_W      = 6,
    parameter int FB_Y_W      = 5,
    localparam int IDX_W      = $clog2(STACK_DEPTH),
    localparam int SP_W       = IDX_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic [17:0]       address,
    input  logic [31:0]       writedata,
    output logic [31:0]       data_out,
    output logic [PC_W-1:0]   pc,
    output logic [15:0]       i_reg,
    output logic [SP_W-1:0]   sp,
    output logic [1:0]        cpu_state,
    output logic              key_pressed,
    output logic [3:0]        key_code,
    output logic              fb_write,
    output logic [FB_X_W-1:0] fb_x,
    output logic [FB_Y_W-1:0] fb_y,
    output logic [7:0]        fb_data,
    output logic [PC_W-1:0]   mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    typedef enum logic [1:0] {RUNNING = 2'd0, PAUSED = 2'd1, LOADING = 2'd2, LOADFONT = 2'd3} state_t;

    state_t state_q, state_d;

    logic            rd, wr, reg_rd, reg_wr, mem_rd, mem_wr;
    logic            full, empty, push_ok, pop_ok, ovf, unf, running;
    logic [1:0]      mrd_pipe;
    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic [PC_W-1:0] top;
    logic [SP_W-1:0] sp_m1;
    logic [31:0]     rd_val;
    logic            unused_ok;

    assign rd      = chipselect & ~write;
    assign wr      = chipselect & write;
    assign reg_rd  = rd & ~address[16];
    assign reg_wr  = wr & ~address[16];
    assign mem_rd  = rd & address[16];
    assign mem_wr  = wr & address[16];
    assign running = (state_q == RUNNING);
    assign full    = (sp == SP_W'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign sp_m1   = sp - SP_W'(1);
    assign top     = empty ? '0 : stack[sp_m1[IDX_W-1:0]];
    assign cpu_state = state_q;
    assign unused_ok = &{1'b0, writedata, address};

`ifdef CHIP8_STACK_GUARD_EN
    assign push_ok = reg_wr && address == 18'h18 && !full;
    assign pop_ok  = reg_wr && address == 18'h19 && !empty;

    // Sticky error flags; a status read acknowledges and clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (reg_rd && address == 18'h19) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (reg_wr && address == 18'h18 && full) begin
            ovf <= 1'b1;
        end else if (reg_wr && address == 18'h19 && empty) begin
            unf <= 1'b1;
        end
    end
`else
    assign push_ok = reg_wr && address == 18'h18;
    assign pop_ok  = reg_wr && address == 18'h19;
    assign ovf     = 1'b0;
    assign unf     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (reg_wr && address == 18'h16)
            state_d = state_t'(writedata[1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= PAUSED;
        else       state_q <= state_d;
    end

    always_comb begin
        rd_val = '0;
        case (address)
            18'h10:  rd_val = {16'b0, i_reg};
            18'h13:  rd_val = 32'(sp);
            18'h14:  rd_val = 32'(pc);
            18'h16:  rd_val = {30'b0, state_q};
            18'h18:  rd_val = 32'(top);
            18'h19:  rd_val = {28'b0, ovf, unf, full, empty};
            default: rd_val = '0;
        endcase
    end

    // Stack storage is not reset; only sp defines what is live.
    always_ff @(posedge clk) begin
        if (push_ok) stack[sp[IDX_W-1:0]] <= writedata[PC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= PC_W'(12'h200);
            i_reg       <= '0;
            sp          <= '0;
            key_pressed <= 1'b0;
            key_code    <= '0;
            fb_write    <= 1'b0;
            fb_x        <= '0;
            fb_y        <= '0;
            fb_data     <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            data_out    <= '0;
            mrd_pipe    <= '0;
        end else begin
            fb_write <= 1'b0;
            mem_we   <= 1'b0;
            mrd_pipe <= {mrd_pipe[0], mem_rd};

            // Memory read: address registered, memory responds a cycle later, then capture.
            if (mrd_pipe[1]) data_out <= {24'b0, mem_rdata};
            if (reg_rd)      data_out <= rd_val;

            if (reg_wr) begin
                case (address)
                    18'h10: i_reg <= writedata[15:0];
                    18'h13: sp    <= writedata[SP_W-1:0];
                    18'h15: begin
                        key_pressed <= writedata[4];
                        key_code    <= writedata[3:0];
                    end
                    18'h17: begin
                        fb_x     <= writedata[16 +: FB_X_W];
                        fb_y     <= writedata[8 +: FB_Y_W];
                        fb_data  <= writedata[7:0];
                        fb_write <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (push_ok)     sp <= sp + SP_W'(1);
            else if (pop_ok) sp <= sp_m1;

            // Host access of any kind stalls the run-mode fetch advance.
            if (reg_wr && address == 18'h14)
                pc <= writedata[PC_W-1:0];
            else if (running && !chipselect)
                pc <= pc + PC_W'(2);

            if (chipselect && address[16])
                mem_addr <= address[PC_W-1:0];
            else if (running && !chipselect)
                mem_addr <= pc + PC_W'(2);

            if (mem_wr && (state_q == LOADING || state_q == LOADFONT)) begin
                mem_we    <= 1'b1;
                mem_wdata <= writedata[7:0];
            end
        end
    end
endmodule
